// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame layout, line levels and transmitter states.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        GUARD = 2'd3
    } ps2_state_e;

    localparam int         FRAME_BITS   = 11;
    localparam logic       START_BIT    = 1'b0;
    localparam logic       STOP_BIT     = 1'b1;
    localparam logic [3:0] LAST_BIT_IDX = 4'(FRAME_BITS - 1);

    // Odd parity: the bit that makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync2.sv
// Two-flop synchroniser for an asynchronous PS/2 line; resets to the idle-high level.
module ps2_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the pin level into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both stages sample the old values, so this stays a two-flop chain.
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/ps2_dev_tx.sv
// Device-side PS/2 transmitter: sends one byte as start, 8 data LSB-first,
// odd parity and stop on ps2clk/ps2data, aborting if the host pulls ps2clk low.
module ps2_dev_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       force_bad_parity,
    input  logic       ps2clk_in,
    output logic       ps2clk,
    output logic       ps2data,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    ps2_state_e  r_state;
    ps2_state_e  w_next_state;
    logic [15:0] r_phase;
    logic [3:0]  r_bit_idx;
    logic [9:0]  r_shift;
    logic        r_ps2clk;
    logic        r_ps2data;
    logic        r_busy;
    logic        r_done;
    logic        r_aborted;

    logic        w_clk_sync;
    logic        w_phase_end;
    logic        w_more_bits;
    logic        w_inhibit;
    logic        w_ps2clk_d;
    logic        w_ps2data_d;
    logic        w_busy_d;
    logic        w_done_d;
    logic        w_aborted_d;

    ps2_sync2 u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (ps2clk_in),
        .o_sync  (w_clk_sync)
    );

    assign w_phase_end = (r_phase == 16'(CLK_DIV - 1));
    assign w_more_bits = (r_bit_idx < LAST_BIT_IDX);
    // The first few HIGH cycles are masked: the synchroniser still shows our own low clock there.
    assign w_inhibit   = (r_state == HIGH) && (r_phase >= 16'd3) && !w_clk_sync;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: each line phase lasts CLK_DIV cycles.
    always_comb begin
        // NOTE: defaulting every comb output first is what keeps this block from inferring latches.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (tx_start)    w_next_state = HIGH;
            HIGH:    if (w_inhibit)   w_next_state = IDLE;
                     else if (w_phase_end) w_next_state = LOW;
            LOW:     if (w_phase_end) w_next_state = w_more_bits ? HIGH : GUARD;
            GUARD:   if (w_phase_end) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic: next values of the registered line and status outputs.
    always_comb begin
        w_ps2clk_d  = r_ps2clk;
        w_ps2data_d = r_ps2data;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_aborted_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_start) begin
                    w_ps2clk_d  = 1'b1;
                    w_ps2data_d = START_BIT;
                    w_busy_d    = 1'b1;
                end
            end
            HIGH: begin
                if (w_inhibit) begin
                    w_ps2clk_d  = 1'b1;
                    w_ps2data_d = 1'b1;
                    w_busy_d    = 1'b0;
                    w_aborted_d = 1'b1;
                end else if (w_phase_end) begin
                    w_ps2clk_d = 1'b0;
                end
            end
            LOW: begin
                // Data only moves together with the rising clock edge.
                if (w_phase_end) begin
                    w_ps2clk_d  = 1'b1;
                    w_ps2data_d = w_more_bits ? r_shift[0] : 1'b1;
                end
            end
            GUARD: begin
                if (w_phase_end) begin
                    w_busy_d = 1'b0;
                    w_done_d = 1'b1;
                end
            end
            default: begin
                w_ps2clk_d  = 1'b1;
                w_ps2data_d = 1'b1;
                w_busy_d    = 1'b0;
            end
        endcase
    end

    // Registered outputs plus phase counter, bit index and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ps2clk  <= 1'b1;
            r_ps2data <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_phase   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_ps2clk  <= w_ps2clk_d;
            r_ps2data <= w_ps2data_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_aborted <= w_aborted_d;

            if (r_state == IDLE || w_next_state != r_state) r_phase <= '0;
            else                                            r_phase <= r_phase + 16'd1;

            if (r_state == IDLE && tx_start) begin
                r_shift   <= {STOP_BIT, odd_parity(tx_data) ^ force_bad_parity, tx_data};
                r_bit_idx <= '0;
            end else if (r_state == LOW && w_phase_end && w_more_bits) begin
                r_shift   <= {1'b0, r_shift[9:1]};
                r_bit_idx <= r_bit_idx + 4'd1;
            end
        end
    end

    assign ps2clk  = r_ps2clk;
    assign ps2data = r_ps2data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule
